// File: rtl/lsm.sv
// lsm: load/store stage, the consumer side of the execute-stage output handshake.
//
// It accepts one execute result per valid/ready handshake. ALU results go
// straight to the register-file write port with one cycle of latency.
// Memory accesses are issued as single pipelined Wishbone transfers. Loads
// write the extracted and extended data back to the register file.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   input_valid_i / input_ready_o execute-output handshake
//   result_write_i, result_addr_i rd write enable and index
//   result_i                      ALU result, or effective address for memory ops
//   ls_enable_i, ls_write_i       memory access and store/load select
//   ls_sel_i, ls_unsigned_load_i  access size (00 byte, 01 half, 1x word) and zero-extend
//   ls_write_data_i               store data (rs2)
//   wb_*                          pipelined Wishbone master
//   reg_write_o, reg_waddr_o,
//   reg_wdata_o                   register-file write port (single-cycle strobe)
module lsm (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        input_valid_i,
   output logic        input_ready_o,
   input  logic        result_write_i,
   input  logic [4:0]  result_addr_i,
   input  logic [31:0] result_i,
   input  logic        ls_enable_i,
   input  logic        ls_write_i,
   input  logic [1:0]  ls_sel_i,
   input  logic        ls_unsigned_load_i,
   input  logic [31:0] ls_write_data_i,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   input  logic        wb_stall_i,
   output logic        reg_write_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQUEST  = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t      state;

   // Attributes of the in-flight memory access, captured at the handshake.
   logic [4:0]  rd_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        unsigned_q;

   logic        transfer;
   logic        done;
   logic [31:0] load_data;
   logic [3:0]  sel_next;
   logic [31:0] dat_next;

   assign transfer = input_valid_i && input_ready_o;

   // An ack only counts once the strobe has been accepted. An ack seen while
   // the slave still stalls is ignored.
   assign done = ((state == REQUEST) && !wb_stall_i && wb_ack_i) ||
                 ((state == WAIT_ACK) && wb_ack_i);

   // Byte lanes and replicated store data for the incoming entry.
   always_comb begin
      sel_next = 4'b1111;
      dat_next = ls_write_data_i;
      case (ls_sel_i)
         2'b00: begin
            sel_next = 4'b0001 << result_i[1:0];
            dat_next = {4{ls_write_data_i[7:0]}};
         end
         2'b01: begin
            sel_next = 4'b0011 << {result_i[1], 1'b0};
            dat_next = {2{ls_write_data_i[15:0]}};
         end
         default: begin
            sel_next = 4'b1111;
            dat_next = ls_write_data_i;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend it.
   always_comb begin
      logic [1:0]  lane;
      logic [31:0] v;
      lane      = (size_q == 2'b00) ? off_q : {off_q[1], 1'b0};
      v         = wb_dat_i >> {lane, 3'b000};
      load_data = wb_dat_i;
      case (size_q)
         2'b00:   load_data = unsigned_q ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
         2'b01:   load_data = unsigned_q ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
         default: load_data = wb_dat_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= IDLE;
         input_ready_o <= 1'b1;
         wb_adr_o      <= '0;
         wb_dat_o      <= '0;
         wb_we_o       <= 1'b0;
         wb_sel_o      <= '0;
         wb_stb_o      <= 1'b0;
         wb_cyc_o      <= 1'b0;
         reg_write_o   <= 1'b0;
         reg_waddr_o   <= '0;
         reg_wdata_o   <= '0;
         rd_q          <= '0;
         size_q        <= '0;
         off_q         <= '0;
         unsigned_q    <= 1'b0;
      end else begin
         reg_write_o <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  if (!ls_enable_i) begin
                     // The write port fields change only on a real write
                     // so they hold their last value otherwise.
                     if (result_write_i && (result_addr_i != 5'd0)) begin
                        reg_write_o <= 1'b1;
                        reg_waddr_o <= result_addr_i;
                        reg_wdata_o <= result_i;
                     end
                  end else begin
                     state         <= REQUEST;
                     input_ready_o <= 1'b0;
                     wb_cyc_o      <= 1'b1;
                     wb_stb_o      <= 1'b1;
                     wb_adr_o      <= {result_i[31:2], 2'b00};
                     wb_sel_o      <= sel_next;
                     wb_dat_o      <= dat_next;
                     wb_we_o       <= ls_write_i;
                     rd_q          <= result_addr_i;
                     size_q        <= ls_sel_i;
                     off_q         <= result_i[1:0];
                     unsigned_q    <= ls_unsigned_load_i;
                  end
               end
            end
            REQUEST: begin
               if (!wb_stall_i) begin
                  wb_stb_o <= 1'b0;
                  if (!wb_ack_i)
                     state <= WAIT_ACK;
               end
            end
            WAIT_ACK: ;
            default: state <= IDLE;
         endcase

         if (done) begin
            state         <= IDLE;
            input_ready_o <= 1'b1;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            if (!wb_we_o && (rd_q != 5'd0)) begin
               reg_write_o <= 1'b1;
               reg_waddr_o <= rd_q;
               reg_wdata_o <= load_data;
            end
         end
      end
   end

endmodule

// File: doc/lsm.md
Name: lsm

Overview:
- Load/store stage: the consumer side of the execute-stage output handshake.
- Accepts the execute result (register write or memory address) with a valid/ready handshake.
- Performs byte, halfword or word loads and stores as a pipelined Wishbone master.
- Drives the register-file write port; branch outputs of execute are consumed by fetch, not here.

Parameters:
none

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-low reset
input_valid_i  input  1  execute output valid
input_ready_o  output  1  this block can accept an entry
result_write_i  input  1  instruction writes rd
result_addr_i  input  5  rd index
result_i  input  32  ALU result, or effective address when ls_enable_i=1
ls_enable_i  input  1  entry is a memory access
ls_write_i  input  1  1=store, 0=load
ls_sel_i  input  2  00 byte, 01 half, 10/11 word
ls_unsigned_load_i  input  1  zero-extend loads (LBU/LHU)
ls_write_data_i  input  32  store data (rs2)
wb_adr_o  output  32  word-aligned address
wb_dat_o  output  32  store data
wb_dat_i  input  32  load data
wb_we_o  output  1  write enable
wb_sel_o  output  4  byte lanes
wb_stb_o  output  1  strobe
wb_cyc_o  output  1  cycle
wb_ack_i  input  1  acknowledge
wb_stall_i  input  1  slave stall
reg_write_o  output  1  register-file write strobe
reg_waddr_o  output  5  register-file write index
reg_wdata_o  output  32  register-file write data

Behaviour:
- Reset: all outputs 0 except input_ready_o=1; FSM goes to IDLE.
- Mid-transaction reset drops cyc and stb immediately, ignores any later ack, and suppresses the register write.
- States: IDLE, REQUEST, WAIT_ACK.
- input_ready_o=1 only in IDLE.
- A transfer occurs when input_valid_i && input_ready_o; all inputs are captured at that edge.
- IDLE, transfer, ls_enable_i=0:
  - Next cycle reg_write_o=result_write_i && (result_addr_i!=0), reg_waddr_o=result_addr_i, reg_wdata_o=result_i.
  - FSM stays in IDLE, so back-to-back transfers give 1-cycle latency at full throughput.
- IDLE, transfer, ls_enable_i=1:
  - Next state is REQUEST; cyc, stb and bus fields are registered and valid the following cycle.
  - wb_adr_o = {result_i[31:2],2'b00}; off = result_i[1:0].
  - wb_sel_o: byte 0001<<off; half 0011<<{off[1],1'b0}; word 1111.
  - wb_dat_o: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - wb_we_o = ls_write_i.
  - Misalignment is trapped upstream; this block ignores off[0] for halfwords and off for words.
- REQUEST: cyc=1, stb=1, all fields held stable while wb_stall_i=1.
  - !wb_stall_i && !wb_ack_i -> WAIT_ACK, stb=0 next cycle.
  - !wb_stall_i && wb_ack_i -> completion.
  - wb_ack_i while stalled is ignored.
- WAIT_ACK: cyc=1, stb=0; wb_ack_i -> completion.
- Completion, registered, takes effect next cycle:
  - cyc=0, state IDLE.
  - Load: reg_write_o=(rd!=0), reg_wdata_o = extracted data.
  - Store: reg_write_o=0.
  - input_ready_o rises the cycle after ack.
- Load extraction: v = wb_dat_i >> (8*lane); lane = off for bytes, {off[1],0} for halfwords.
  - Byte: sign or zero extend v[7:0].
  - Half: sign or zero extend v[15:0].
  - Word: wb_dat_i unchanged.
- reg_write_o is a single-cycle pulse.
- reg_waddr_o and reg_wdata_o hold their last value when reg_write_o=0.
- No transaction is ever issued without cyc; cyc never drops before ack except on reset.

Test Plan:
- ALU passthrough: 3 back-to-back valid entries (rd=5,6,0; results 0x11,0x22,0x33), ls_enable_i=0 -> reg_write_o pulses for rd 5 and 6 on consecutive cycles, none for rd 0; input_ready_o stays 1.
- Signed byte load: addr 0x1003, wb_dat_i=0x80AABBCC, ack 2 cycles after stb accepted -> wb_adr_o=0x1000, wb_sel_o=1000, reg_wdata_o=0xFFFFFF80; LBU variant gives 0x00000080.
- Halfword store: addr 0x2002, data 0x1234ABCD, wb_stall_i=1 for 3 cycles -> stb/adr/sel held; then wb_sel_o=1100, wb_dat_o=0xABCDABCD, we=1; no reg write; ready returns the cycle after ack.
- Same-cycle ack: word load at 0x3000, ack with stb unstalled, wb_dat_i=0xDEADBEEF -> no WAIT_ACK cycle; reg_wdata_o=0xDEADBEEF next cycle.
- Backpressure: input_valid_i held high during a load -> input_ready_o=0 from REQUEST until the cycle after ack; the second entry is accepted exactly once.
- Reset mid-transaction: rst_i low in WAIT_ACK, then ack arrives -> cyc/stb=0 immediately, reg_write_o never asserts, input_ready_o=1 after release.
